// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4
//   Rebuilds four parallel channels from a time-division-multiplexed serial
//   stream. There is one sample per slot, in slot order 0,1,2,3, and a sync
//   marker flags slot 0. A HUNT/RUN state machine locks onto the frame.
//   Each completed frame is presented as one parallel word with a one-cycle
//   strobe.
//
//   state | meaning
//   HUNT  | not locked; valid samples are dropped until a sync sample arrives
//   RUN   | locked; samples fill the staging slots, and slot 3 publishes the frame
//
// Ports
//   clk_in           single clock, rising edge
//   rst_n_in         synchronous active-low reset
//   y_in             serial sample for the current slot
//   valid_in         y_in carries a sample this cycle
//   sync_in          current valid sample is slot 0
//   d_out            last complete frame, channel k at [k*DATA_W +: DATA_W]
//   frame_valid_out  one-cycle pulse, d_out updated this cycle
//   sel_out          slot index expected for the next valid sample
//   locked_out       FSM is in RUN
//   frame_err_out    one-cycle pulse, sync seen at a slot other than 0
module tdm_demux_1to4 #(
  parameter int DATA_W = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [DATA_W-1:0]     y_in,
  input  logic                  valid_in,
  input  logic                  sync_in,
  output logic [4*DATA_W-1:0]   d_out,
  output logic                  frame_valid_out,
  output logic [1:0]            sel_out,
  output logic                  locked_out,
  output logic                  frame_err_out
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [1:0]            sel_q, sel_d;
  // Slots 0..2 only. Slot 3 goes straight from y_in into the published word.
  logic [3*DATA_W-1:0]   stage_q, stage_d;
  logic [4*DATA_W-1:0]   data_q, data_d;
  logic                  fv_q, fv_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    stage_d = stage_q;
    data_d  = data_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;

    if (valid_in) begin
      case (state_q)
        HUNT: begin
          if (sync_in) begin
            stage_d[0 +: DATA_W] = y_in;
            sel_d                = 2'd1;
            state_d              = RUN;
          end
        end
        RUN: begin
          if (sync_in && (sel_q != 2'd0)) begin
            // Resync: drop the partial frame and restart at slot 0.
            // The published word is left untouched.
            err_d                = 1'b1;
            stage_d[0 +: DATA_W] = y_in;
            sel_d                = 2'd1;
          end else begin
            // Slot 0 is accepted with or without sync, so a free-running
            // stream only needs to send the marker once.
            case (sel_q)
              2'd0:    stage_d[0 +: DATA_W]        = y_in;
              2'd1:    stage_d[DATA_W +: DATA_W]   = y_in;
              2'd2:    stage_d[2*DATA_W +: DATA_W] = y_in;
              default: begin
                data_d = {y_in, stage_q};
                fv_d   = 1'b1;
              end
            endcase
            sel_d = sel_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= HUNT;
      sel_q   <= 2'd0;
      stage_q <= '0;
      data_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      stage_q <= stage_d;
      data_q  <= data_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign d_out           = data_q;
  assign frame_valid_out = fv_q;
  assign frame_err_out   = err_q;
  assign sel_out         = sel_q;
  assign locked_out      = (state_q == RUN);

endmodule

// File: tb/tb_tdm_demux_1to4.sv
module tb_tdm_demux_1to4;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [0:0] y_in;
  logic       valid_in;
  logic       sync_in;
  logic [3:0] d_out;
  logic       frame_valid_out;
  logic [1:0] sel_out;
  logic       locked_out;
  logic       frame_err_out;

  always #5 clk_in = ~clk_in;

  tdm_demux_1to4 #(.DATA_W(1)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .y_in            (y_in),
    .valid_in        (valid_in),
    .sync_in         (sync_in),
    .d_out           (d_out),
    .frame_valid_out (frame_valid_out),
    .sel_out         (sel_out),
    .locked_out      (locked_out),
    .frame_err_out   (frame_err_out)
  );

  int vectors = 0;
  int errs    = 0;

  // Reference model: a locked flag, the next slot number, the captured
  // samples of the frame in progress and the last published frame.
  bit       m_locked;
  int       m_slot;
  bit       m_stage [4];
  bit [3:0] m_d;
  bit       m_fv;
  bit       m_err;

  wire [8:0] dut_word = {d_out, frame_valid_out, frame_err_out, sel_out, locked_out};

  function automatic logic [8:0] exp_word();
    logic [1:0] s2;
    s2 = 2'(m_slot);
    return {m_d, m_fv, m_err, s2, m_locked};
  endfunction

  // Drive one clock cycle from the falling edge, then advance the model.
  task automatic cycle(input bit r, input bit v, input bit s, input bit y);
    rst_n_in = r;
    valid_in = v;
    sync_in  = s;
    y_in     = y;
    @(posedge clk_in);
    m_fv  = 0;
    m_err = 0;
    if (!r) begin
      m_locked = 0;
      m_slot   = 0;
      m_d      = '0;
      foreach (m_stage[k]) m_stage[k] = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_stage[0] = y;
          m_slot     = 1;
          m_locked   = 1;
        end
      end else if (s && m_slot != 0) begin
        m_err      = 1;
        m_stage[0] = y;
        m_slot     = 1;
      end else begin
        m_stage[m_slot] = y;
        if (m_slot == 3) begin
          m_d  = {y, m_stage[2], m_stage[1], m_stage[0]};
          m_fv = 1;
        end
        m_slot = (m_slot + 1) % 4;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 1, 1'($urandom));
      vectors++;
      if (dut_word !== 9'd0) begin
        errs++;
        $display("FAIL reset cyc%0d got %b exp %b", i, dut_word, 9'd0);
      end
    end
  endtask

  task automatic test_lock();
    bit [3:0] pat = 4'b1101;
    int fv_cnt = 0;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, i == 0, pat[i]);
      fv_cnt += int'(frame_valid_out);
      vectors++;
      if (dut_word !== exp_word()) begin
        errs++;
        $display("FAIL lock cyc%0d got %b exp %b", i, dut_word, exp_word());
      end
    end
    vectors++;
    if ({d_out, frame_valid_out, locked_out, sel_out} !== {4'b1101, 1'b1, 1'b1, 2'd0}) begin
      errs++;
      $display("FAIL lock_final got d=%b fv=%b lk=%b sel=%0d exp d=1101 fv=1 lk=1 sel=0",
               d_out, frame_valid_out, locked_out, sel_out);
    end
    cycle(1, 0, 0, 0);
    vectors++;
    if ({d_out, frame_valid_out} !== {4'b1101, 1'b0} || fv_cnt != 1) begin
      errs++;
      $display("FAIL lock_hold got d=%b fv=%b pulses=%0d exp d=1101 fv=0 pulses=1",
               d_out, frame_valid_out, fv_cnt);
    end
  endtask

  task automatic test_hunt_drop();
    bit [3:0] pat = 4'b0110;
    int fv_cnt = 0;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i < 3) cycle(1, 1, 0, 1'($urandom));
      else       cycle(1, 1, i == 3, pat[i-3]);
      fv_cnt += int'(frame_valid_out);
      vectors++;
      if (dut_word !== exp_word()) begin
        errs++;
        $display("FAIL hunt_drop cyc%0d got %b exp %b", i, dut_word, exp_word());
      end
    end
    vectors++;
    if (d_out !== 4'b0110 || fv_cnt != 1) begin
      errs++;
      $display("FAIL hunt_drop_final got d=%b pulses=%0d exp d=0110 pulses=1", d_out, fv_cnt);
    end
  endtask

  task automatic test_resync();
    bit [3:0] old_d = 4'($urandom);
    bit       seq_s [6] = '{1, 0, 1, 0, 0, 0};
    bit       seq_y [6] = '{1, 1, 0, 0, 0, 1};
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, i == 0, old_d[i]);
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, seq_s[i], seq_y[i]);
      vectors++;
      if (dut_word !== exp_word()) begin
        errs++;
        $display("FAIL resync cyc%0d got %b exp %b", i, dut_word, exp_word());
      end
      if (i == 2) begin
        vectors++;
        if ({frame_err_out, frame_valid_out, d_out} !== {1'b1, 1'b0, old_d}) begin
          errs++;
          $display("FAIL resync_err got err=%b fv=%b d=%b exp err=1 fv=0 d=%b",
                   frame_err_out, frame_valid_out, d_out, old_d);
        end
      end
    end
    vectors++;
    if (d_out !== 4'b1000) begin
      errs++;
      $display("FAIL resync_final got d=%b exp d=1000", d_out);
    end
  endtask

  task automatic test_gapped();
    bit [3:0] pat = 4'b1001;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      int gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        cycle(1, 0, 1'($urandom), 1'($urandom));
        vectors++;
        if (dut_word !== exp_word()) begin
          errs++;
          $display("FAIL gapped_idle slot%0d got %b exp %b", i, dut_word, exp_word());
        end
      end
      cycle(1, 1, i == 0, pat[i]);
      vectors++;
      if (dut_word !== exp_word()) begin
        errs++;
        $display("FAIL gapped slot%0d got %b exp %b", i, dut_word, exp_word());
      end
    end
    vectors++;
    if (d_out !== 4'b1001) begin
      errs++;
      $display("FAIL gapped_final got d=%b exp d=1001", d_out);
    end
  endtask

  task automatic test_back_to_back();
    int fv_cnt = 0;
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, i == 0, 1'($urandom));
      fv_cnt += int'(frame_valid_out);
      vectors++;
      if (dut_word !== exp_word() || frame_valid_out !== (i % 4 == 3)) begin
        errs++;
        $display("FAIL stream cyc%0d got %b exp %b", i, dut_word, exp_word());
      end
    end
    vectors++;
    if (fv_cnt != 5) begin
      errs++;
      $display("FAIL stream_count got %0d exp 5", fv_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    cycle(0, 0, 0, 0);
    cycle(1, 1, 1, 1);
    cycle(1, 1, 0, 1);
    cycle(0, 1, 0, 1);
    vectors++;
    if (dut_word !== 9'd0) begin
      errs++;
      $display("FAIL midreset got %b exp %b", dut_word, 9'd0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1, 1, 0, 1'($urandom));
      vectors++;
      if (dut_word !== 9'd0) begin
        errs++;
        $display("FAIL midreset_nosync cyc%0d got %b exp %b", i, dut_word, 9'd0);
      end
    end
  endtask

  task automatic test_random();
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 6) == 0, 1'($urandom));
      vectors++;
      if (dut_word !== exp_word() || (frame_valid_out && frame_err_out)) begin
        errs++;
        $display("FAIL random cyc%0d got %b exp %b", i, dut_word, exp_word());
      end
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    valid_in = 1'b0;
    sync_in  = 1'b0;
    y_in     = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_lock();
    test_hunt_drop();
    test_resync();
    test_gapped();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
